// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (receiver now, transmitter later).
//   rx_state_t      : receiver FSM states
//   UART_DATA_BITS  : default data bits per frame
//   UART_OVERSAMPLE : default oversample strobes per bit period
//   clog2()         : counter width helper, never returns less than 1
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Bits needed to count 0..value-1; a one-state counter still gets 1 bit.
    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit.
//   clock     in  : destination clock
//   resetn    in  : asynchronous active-low reset
//   d         in  : asynchronous input
//   q         out : synchronized output, 2 clocks of latency
// Both flops reset to RESET_VAL so an idle-high line does not look like an
// edge when reset releases.
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver fed by a free-running toggling baud tick. Every tick edge is
// one oversample strobe. Recovers start/data/stop frames (LSB first) and holds
// the received byte in a single-entry output register.
//
// Ports:
//   clock       in   system clock
//   resetn      in   asynchronous active-low reset
//   tickIn      in   toggling tick from the baud generator (clock-synchronous)
//   rxd         in   asynchronous serial line, idle high
//   rxData      out  last accepted byte
//   rxValid     out  rxData holds an unconsumed byte
//   rxReady     in   consumer accepts
//   frameError  out  one-cycle pulse: stop bit sampled as 0, byte discarded
//   overrun     out  one-cycle pulse: completed byte dropped, output was full
//   dbg_state   out  current FSM state, for observation only
//
// Handshake: a transfer happens on every clock edge where rxValid && rxReady.
// rxValid, once set, stays high until such a transfer; rxData is stable while
// rxValid is high. rxReady is don't-care while rxValid is low.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 tickIn,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    input  logic                 rxReady,
    output logic                 frameError,
    output logic                 overrun,
    output rx_state_t            dbg_state
);

    localparam int SW = clog2(OVERSAMPLE);
    localparam int BW = clog2(DATA_BITS + 1);

    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 tick_prev;
    logic                 strobe;
    logic                 rxs;
    logic                 rxs_prev;
    logic                 fall;

    rx_state_t            state;
    rx_state_t            state_next;
    logic [SW-1:0]        s_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    logic                 sample_data;
    logic                 deliver;
    logic                 stop_bad;
    logic                 load;

    // ---------------------------------------------------------------
    // Strobe and line edge detection
    // ---------------------------------------------------------------
    assign strobe = tickIn ^ tick_prev;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clock  (clock),
        .resetn (resetn),
        .d      (rxd),
        .q      (rxs)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tick_prev <= 1'b0;
            rxs_prev  <= 1'b1;
        end else begin
            tick_prev <= tickIn;
            rxs_prev  <= rxs;
        end
    end

    // Only a high-to-low transition starts a frame, so a line held low
    // (break, or a bad stop bit that stays low) cannot retrigger.
    assign fall = rxs_prev & ~rxs;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        sample_data = 1'b0;
        deliver     = 1'b0;
        stop_bad    = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_next = START;
                end
            end
            START: begin
                // Mid start bit: a high line here was just a glitch.
                if (strobe && (s_cnt == S_MID)) begin
                    state_next = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (strobe && (s_cnt == S_LAST)) begin
                    sample_data = 1'b1;
                    if (bit_cnt == B_LAST) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving here mid stop bit leaves half a bit of margin
                // before a back-to-back start edge.
                if (strobe && (s_cnt == S_LAST)) begin
                    state_next = IDLE;
                    if (rxs) begin
                        deliver = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dbg_state = state;

    // ---------------------------------------------------------------
    // Counters and shift register
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s_cnt <= '0;
        end else if (state_next != state) begin
            s_cnt <= '0;
        end else if (strobe) begin
            // Explicit wrap keeps non-power-of-two OVERSAMPLE exact.
            s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + SW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if ((state == START) && (state_next == DATA)) begin
                bit_cnt <= '0;
            end else if (sample_data) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (sample_data) begin
                // LSB arrives first, so after DATA_BITS right shifts it
                // sits in bit 0.
                shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
            end
        end
    end

    // ---------------------------------------------------------------
    // Single-entry output register
    // ---------------------------------------------------------------
    // A consume in the same cycle frees the slot, so it is not an overrun.
    assign load = deliver & (~rxValid | rxReady);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rxData     <= '0;
            rxValid    <= 1'b0;
            frameError <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frameError <= stop_bad;
            overrun    <= deliver & rxValid & ~rxReady;
            if (load) begin
                rxData  <= shift_reg;
                rxValid <= 1'b1;
            end else if (rxValid && rxReady) begin
                rxValid <= 1'b0;
            end
        end
    end

endmodule
